// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master
// Single-master AHB-Lite initiator: converts a valid/ready command stream into
// pipelined NONSEQ single transfers and returns one response per transfer.
// Optional build macro AHB_MST_ERR_CANCEL_EN: when defined, an address phase
// pending behind an ERROR response is cancelled and answered with rsp_err=1.
module ahb_lite_cmd_master #(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_size,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    // Force the low address bits to the natural alignment of the transfer size.
    function automatic logic [AW-1:0] f_align(input logic [AW-1:0] a, input logic [1:0] sz);
        logic [AW-1:0] r;
        r = a;
        if (sz == 2'd1)
            r[0] = 1'b0;
        else if (sz[1])
            r[1:0] = 2'b00;
        return r;
    endfunction

    // Map command size to HSIZE; size 3 is treated as a word.
    function automatic logic [2:0] f_hsize(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    // Replicate right-justified write data across all byte lanes.
    function automatic logic [31:0] f_lanes(input logic [31:0] w, input logic [2:0] hs);
        case (hs[1:0])
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Shift the addressed lanes down and zero-extend to the transfer size.
    function automatic logic [31:0] f_extract(input logic [31:0] rd, input logic [1:0] lo,
                                              input logic [2:0] hs);
        logic [31:0] sh;
        sh = rd >> {lo, 3'b000};
        case (hs[1:0])
            2'd0:    return {24'h0, sh[7:0]};
            2'd1:    return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Address slot
    logic          r_a_vld;
    logic [AW-1:0] r_haddr;
    logic          r_hwrite;
    logic [2:0]    r_hsize;
    logic [31:0]   r_a_wdata;

    // Data slot
    logic          r_d_vld;
    logic          r_d_write;
    logic [2:0]    r_d_size;
    logic [1:0]    r_d_addr_lo;
    logic [31:0]   r_d_wdata;

    logic          r_err_hold;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;

    logic          w_accept;
    logic          w_a_done;
    logic          w_d_done;
    logic          w_err_first;
    logic          w_cancel;
    logic          w_cxl_fire;

    assign cmd_ready   = ~HRESET & (~r_a_vld | HREADY) & ~r_err_hold;
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_a_done    = r_a_vld & HREADY;
    assign w_d_done    = r_d_vld & HREADY;
    assign w_err_first = r_d_vld & HRESP & ~HREADY & ~r_err_hold;

`ifdef AHB_MST_ERR_CANCEL_EN
    logic r_cxl_arm;
    logic r_cxl_fire;

    assign w_cancel   = w_err_first & r_a_vld;
    assign w_cxl_fire = r_cxl_fire;

    // Track a cancelled command: armed at the first error cycle, answered one cycle after the errored response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_cxl_arm  <= 1'b0;
            r_cxl_fire <= 1'b0;
        end else begin
            r_cxl_fire <= 1'b0;
            if (w_cancel)
                r_cxl_arm <= 1'b1;
            else if (r_cxl_arm && w_d_done) begin
                r_cxl_arm  <= 1'b0;
                r_cxl_fire <= 1'b1;
            end
        end
    end
`else
    assign w_cancel   = 1'b0;
    assign w_cxl_fire = 1'b0;
`endif

    // Address slot: load on accept, retire when the address phase completes, drop on cancel.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_a_vld   <= 1'b0;
            r_haddr   <= '0;
            r_hwrite  <= 1'b0;
            r_hsize   <= 3'b000;
            r_a_wdata <= '0;
        end else if (w_cancel) begin
            r_a_vld <= 1'b0;
        end else if (w_accept) begin
            r_a_vld   <= 1'b1;
            r_haddr   <= f_align(cmd_addr, cmd_size);
            r_hwrite  <= cmd_write;
            r_hsize   <= f_hsize(cmd_size);
            r_a_wdata <= cmd_wdata;
        end else if (w_a_done) begin
            r_a_vld <= 1'b0;
        end
    end

    // Data slot: takes over a completed address phase, empties when its data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_d_vld     <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_size    <= 3'b000;
            r_d_addr_lo <= 2'b00;
            r_d_wdata   <= '0;
        end else if (w_a_done) begin
            r_d_vld     <= 1'b1;
            r_d_write   <= r_hwrite;
            r_d_size    <= r_hsize;
            r_d_addr_lo <= r_haddr[1:0];
            r_d_wdata   <= r_a_wdata;
        end else if (w_d_done) begin
            r_d_vld <= 1'b0;
        end
    end

    // Error hold: blocks new commands from the first ERROR cycle until the errored transfer ends.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            r_err_hold <= 1'b0;
        else if (w_d_done)
            r_err_hold <= 1'b0;
        else if (w_err_first)
            r_err_hold <= 1'b1;
    end

    // Response strobe: one pulse per completed data phase or cancelled command.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_d_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= HRESP;
            r_rsp_rdata <= r_d_write ? 32'h0 : f_extract(HRDATA, r_d_addr_lo, r_d_size);
        end else if (w_cxl_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign HADDR     = r_haddr;
    assign HTRANS    = r_a_vld ? HT_NONSEQ : HT_IDLE;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HWDATA    = r_d_vld ? f_lanes(r_d_wdata, r_d_size) : 32'h0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_a_vld | r_d_vld;

endmodule
